// File: rtl/board_row_fetcher.sv
// rtl/board_row_fetcher.sv - fetches one board row from RAM into a shadow buffer and commits it atomically (optional feature: PIECE_OVERLAY_EN)
module board_row_fetcher #(
  parameter int BOARD_W = 10,
  parameter int BOARD_H = 20,
  parameter int CELL_W  = 16,
  parameter int RD_LAT  = 1
) (
  input  logic                             Clk,
  input  logic                             reset_n,
  input  logic                             LD_Row,
  input  logic [7:0]                       rowNum,
  output logic [7:0]                       ram_addr,
  output logic                             ram_rd,
  input  logic [CELL_W-1:0]                ram_rdata,
  output logic [BOARD_W-1:0][CELL_W-1:0]   Row,
  output logic                             rowReady,
`ifdef PIECE_OVERLAY_EN
  input  logic [3:0][3:0]                  piece_x,
  input  logic [3:0][4:0]                  piece_y,
  input  logic [CELL_W-1:0]                piece_color,
`endif
  output logic                             busy
);

  localparam int COL_W = $clog2(BOARD_W);
  localparam logic [COL_W-1:0] LAST_COL = COL_W'(BOARD_W - 1);

  // The capture pipeline below assumes the RAM returns data exactly one cycle after the strobe.
  generate
    if (RD_LAT != 1) begin : g_lat_check
      $error("board_row_fetcher supports RD_LAT == 1 only");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, READ, DRAIN, COMMIT} state_t;

  state_t                           state, state_nxt;
  logic                             ld_prev;
  logic                             req;
  logic [7:0]                       req_row;
  logic [7:0]                       cur_row;
  logic [COL_W-1:0]                 col;
  logic [COL_W-1:0]                 cap_col;
  logic [CELL_W-1:0]                cap_data;
  logic                             pend_valid;
  logic [7:0]                       pend_row;
  logic [BOARD_W-1:0][CELL_W-1:0]   shadow;
`ifdef PIECE_OVERLAY_EN
  logic [3:0][3:0]                  cur_px, pend_px;
  logic [3:0][4:0]                  cur_py, pend_py;
  logic [CELL_W-1:0]                cur_pc, pend_pc;
`endif

  // Rows past the bottom of the board wrap to row 0, matching the mapper's end-of-frame wrap.
  function automatic logic [7:0] clamp_row(input logic [7:0] r);
    return (int'(r) >= BOARD_H) ? 8'd0 : r;
  endfunction

  assign req      = LD_Row & ~ld_prev;
  assign req_row  = clamp_row(rowNum);
  assign busy     = (state != IDLE);
  assign ram_rd   = (state == READ);
  assign ram_addr = (state == READ) ? 8'(int'(cur_row) * BOARD_W + int'(col)) : 8'd0;
  // Data on ram_rdata belongs to the address issued one cycle earlier.
  assign cap_col  = (state == DRAIN) ? LAST_COL : col - 1'b1;

  // Captured cell value, with the active piece painted over the RAM content when enabled.
  always_comb begin
    cap_data = ram_rdata;
`ifdef PIECE_OVERLAY_EN
    for (int i = 0; i < 4; i++) begin
      if ((32'(cur_py[i]) == 32'(cur_row)) && (32'(cur_px[i]) == 32'(cap_col))) begin
        cap_data = cur_pc;
      end
    end
`endif
  end

  // State register.
  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // Next-state logic: a pending or same-cycle request chains straight into another fetch after commit.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req) state_nxt = READ;
      READ:    if (col == LAST_COL) state_nxt = DRAIN;
      DRAIN:   state_nxt = COMMIT;
      COMMIT:  state_nxt = (req || pend_valid) ? READ : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: edge detect, row/column counters, shadow capture, pending slot and atomic commit.
  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) begin
      // Treat the level as already high so a request held through reset is not seen as an edge.
      ld_prev    <= 1'b1;
      cur_row    <= 8'd0;
      col        <= '0;
      pend_valid <= 1'b0;
      pend_row   <= 8'd0;
      shadow     <= '0;
      Row        <= '0;
      rowReady   <= 1'b0;
`ifdef PIECE_OVERLAY_EN
      cur_px  <= '0;
      cur_py  <= '0;
      cur_pc  <= '0;
      pend_px <= '0;
      pend_py <= '0;
      pend_pc <= '0;
`endif
    end else begin
      ld_prev  <= LD_Row;
      rowReady <= 1'b0;
      case (state)
        IDLE: begin
          if (req) begin
            cur_row <= req_row;
            col     <= '0;
`ifdef PIECE_OVERLAY_EN
            cur_px <= piece_x;
            cur_py <= piece_y;
            cur_pc <= piece_color;
`endif
          end
        end
        READ: begin
          col <= col + 1'b1;
          if (col != '0) shadow[cap_col] <= cap_data;
        end
        DRAIN: begin
          shadow[cap_col] <= cap_data;
        end
        COMMIT: begin
          Row        <= shadow;
          rowReady   <= 1'b1;
          col        <= '0;
          pend_valid <= 1'b0;
          // A request arriving in this very cycle is newer than anything parked in the pending slot.
          if (req) begin
            cur_row <= req_row;
`ifdef PIECE_OVERLAY_EN
            cur_px <= piece_x;
            cur_py <= piece_y;
            cur_pc <= piece_color;
`endif
          end else if (pend_valid) begin
            cur_row <= pend_row;
`ifdef PIECE_OVERLAY_EN
            cur_px <= pend_px;
            cur_py <= pend_py;
            cur_pc <= pend_pc;
`endif
          end
        end
        default: ;
      endcase
      // Requests during a fetch park in a one-deep slot; the newest one overwrites.
      if (req && (state == READ || state == DRAIN)) begin
        pend_valid <= 1'b1;
        pend_row   <= req_row;
`ifdef PIECE_OVERLAY_EN
        pend_px <= piece_x;
        pend_py <= piece_y;
        pend_pc <= piece_color;
`endif
      end
    end
  end

endmodule
